// File: rtl/lcd_text_overlay_pkg.sv
// lcd_text_overlay_pkg: colour constants, config field codes and region config record
// shared by the text overlay renderer and its glyph ROMs.
package lcd_text_overlay_pkg;

    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] YELLOW = 24'hFFFF00;

    localparam logic [2:0] F_CTRL = 3'd0;
    localparam logic [2:0] F_X0   = 3'd1;
    localparam logic [2:0] F_Y0   = 3'd2;
    localparam logic [2:0] F_FG   = 3'd3;
    localparam logic [2:0] F_BG   = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_BLINK  = 1;
    localparam int CTRL_TRANSP = 2;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [10:0] x0;
        logic [10:0] y0;
        logic [23:0] fg;
        logic [23:0] bg;
    } region_cfg_t;

    function automatic region_cfg_t cfg_reset(input logic [23:0] bg);
        region_cfg_t c;
        c.ctrl = '0;
        c.x0   = '0;
        c.y0   = '0;
        c.fg   = BLUE;
        c.bg   = bg;
        return c;
    endfunction

endpackage

// File: rtl/lcd_glyph_rom.sv
// lcd_glyph_rom: synchronous one-cycle-read glyph bitmap; one word per pixel column,
// MSB is the top row. Contents come from INIT_FILE at implementation time.
module lcd_glyph_rom #(
    parameter int DEPTH     = 512,
    parameter int WIDTH     = 64,
    parameter     INIT_FILE = "vip_rom0.mif"
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         q
);

    (* rom_init_file = INIT_FILE *)
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        q <= mem[addr];

endmodule

// File: rtl/lcd_text_overlay.sv
// lcd_text_overlay: composites up to NUM_REGION glyph regions over DEFAULT_COLOR with a
// fixed 2-cycle coordinate-to-pixel latency and frame-synchronous config update.
module lcd_text_overlay
    import lcd_text_overlay_pkg::*;
#(
    parameter int          NUM_REGION    = 2,
    parameter int          REGION_W      = 512,
    parameter int          GLYPH_H       = 64,
    parameter logic [23:0] DEFAULT_COLOR = YELLOW,
    parameter int          BLINK_FRAMES  = 30,
    parameter              INIT_PREFIX   = "vip_rom"
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [10:0]                       lcd_xpos,
    input  logic [10:0]                       lcd_ypos,
    input  logic                              cfg_we,
    input  logic [3+$clog2(NUM_REGION)-1:0]   cfg_addr,
    input  logic [23:0]                       cfg_wdata,
    output logic [23:0]                       lcd_data
);

    localparam int CW = 3 + $clog2(NUM_REGION);
    localparam int AW = $clog2(REGION_W);
    localparam int RB = $clog2(GLYPH_H);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic          at_zero, prev_zero, fs, wrap, phase, phase_eff;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    fld;
    logic [NUM_REGION-1:0] draw;
    logic [23:0]   color [NUM_REGION];
    logic [23:0]   pix;

    assign at_zero   = lcd_xpos == '0 && lcd_ypos == '0;
    assign fs        = at_zero && !prev_zero;
    assign wrap      = frame_cnt == FW'(BLINK_FRAMES - 1);
    assign phase_eff = (fs && wrap) ? !phase : phase;
    assign fld       = cfg_addr[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_zero <= 1'b0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            prev_zero <= at_zero;
            if (fs) begin
                frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
                phase     <= phase_eff;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGION; i++) begin : g_region
        region_cfg_t      shadow, active, eff;
        logic             wsel, inx, iny, hit;
        logic [11:0]      dx, dy;
        logic             hit_q, tr_q;
        logic [RB-1:0]    row_q;
        logic [23:0]      fg_q, bg_q;
        logic [GLYPH_H-1:0] q;

        assign wsel = cfg_we && (cfg_addr >> 3) == CW'(i);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow <= cfg_reset(DEFAULT_COLOR);
                active <= cfg_reset(DEFAULT_COLOR);
            end else begin
                if (fs) active <= shadow;
                if (wsel && fld == F_CTRL) shadow.ctrl <= cfg_wdata[2:0];
                if (wsel && fld == F_X0)   shadow.x0   <= cfg_wdata[10:0];
                if (wsel && fld == F_Y0)   shadow.y0   <= cfg_wdata[10:0];
                if (wsel && fld == F_FG)   shadow.fg   <= cfg_wdata;
                if (wsel && fld == F_BG)   shadow.bg   <= cfg_wdata;
            end
        end

        // the frame-start pixel already sees the freshly loaded config
        assign eff = fs ? shadow : active;
        assign dx  = {1'b0, lcd_xpos} - {1'b0, eff.x0};
        assign dy  = {1'b0, lcd_ypos} - {1'b0, eff.y0};
        assign inx = {1'b0, lcd_xpos} >= {1'b0, eff.x0} && dx < 12'(REGION_W);
        assign iny = {1'b0, lcd_ypos} >= {1'b0, eff.y0} && dy < 12'(GLYPH_H);
        assign hit = eff.ctrl[CTRL_EN] && inx && iny && !(eff.ctrl[CTRL_BLINK] && phase_eff);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hit_q <= 1'b0;
                tr_q  <= 1'b0;
                row_q <= '0;
                fg_q  <= '0;
                bg_q  <= '0;
            end else begin
                hit_q <= hit;
                tr_q  <= eff.ctrl[CTRL_TRANSP];
                row_q <= RB'(GLYPH_H - 1) - dy[RB-1:0];
                fg_q  <= eff.fg;
                bg_q  <= eff.bg;
            end
        end

        lcd_glyph_rom #(
            .DEPTH    (REGION_W),
            .WIDTH    (GLYPH_H),
            .INIT_FILE({INIT_PREFIX, 8'(8'd48 + i), ".mif"})
        ) u_rom (
            .clk (clk),
            .addr(dx[AW-1:0]),
            .q   (q)
        );

        assign draw[i]  = hit_q && (q[row_q] || !tr_q);
        assign color[i] = q[row_q] ? fg_q : bg_q;
    end

    always_comb begin
        pix = DEFAULT_COLOR;
        for (int k = NUM_REGION - 1; k >= 0; k--)
            pix = draw[k] ? color[k] : pix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lcd_data <= '0;
        else     lcd_data <= pix;
    end

endmodule

// File: tb/tb_lcd_text_overlay.sv
// tb_lcd_text_overlay: randomized and directed stimulus checked against a pixel-level
// reference model of region placement, priority, frame-synchronous config and blink.
module tb_lcd_text_overlay;

    localparam int          NR  = 2;
    localparam int          W   = 512;
    localparam int          H   = 64;
    localparam int          BF  = 2;
    localparam logic [23:0] DEF = 24'hFFFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] xpos = '0, ypos = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [23:0] cfg_wdata = '0;
    logic [23:0] lcd_data;

    always #5 clk = ~clk;

    lcd_text_overlay #(
        .NUM_REGION   (NR),
        .REGION_W     (W),
        .GLYPH_H      (H),
        .DEFAULT_COLOR(DEF),
        .BLINK_FRAMES (BF),
        .INIT_PREFIX  ("vip_rom")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lcd_xpos (xpos),
        .lcd_ypos (ypos),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .lcd_data (lcd_data)
    );

    typedef struct {
        bit          en, blink, tr;
        int          x0, y0;
        logic [23:0] fg, bg;
    } reg_t;

    logic [63:0] rom_m [NR][W];
    reg_t        sh [NR];
    reg_t        ac [NR];
    int          frames;
    bit          prev0;
    logic [23:0] expq [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input int x, input int y, input bit ph);
        logic [63:0] col;
        for (int r = 0; r < NR; r++) begin
            if (ac[r].en && !(ac[r].blink && ph) && x >= ac[r].x0 && x < ac[r].x0 + W &&
                y >= ac[r].y0 && y < ac[r].y0 + H) begin
                col = rom_m[r][x - ac[r].x0];
                if (col[H - 1 - (y - ac[r].y0)]) return ac[r].fg;
                if (!ac[r].tr) return ac[r].bg;
            end
        end
        return DEF;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            sh[r].en = 0; sh[r].blink = 0; sh[r].tr = 0;
            sh[r].x0 = 0; sh[r].y0 = 0;
            sh[r].fg = 24'h0000FF; sh[r].bg = DEF;
            ac[r] = sh[r];
        end
        frames = 0;
        prev0  = 0;
        expq.delete();
    endtask

    task automatic cycle(input int x, input int y, input bit we, input int addr,
                         input logic [23:0] data, input string tag);
        bit ph;
        int r, f;
        xpos = 11'(x); ypos = 11'(y);
        cfg_we = we; cfg_addr = 4'(addr); cfg_wdata = data;
        if (x == 0 && y == 0 && !prev0) begin
            for (int k = 0; k < NR; k++) ac[k] = sh[k];
            frames++;
        end
        ph = ((frames / BF) % 2) == 1;
        expq.push_back(model_pix(x, y, ph));
        if (we) begin
            r = addr >> 3;
            f = addr & 7;
            if (r < NR) begin
                if (f == 0) begin
                    sh[r].en = data[0]; sh[r].blink = data[1]; sh[r].tr = data[2];
                end
                if (f == 1) sh[r].x0 = int'(data[10:0]);
                if (f == 2) sh[r].y0 = int'(data[10:0]);
                if (f == 3) sh[r].fg = data;
                if (f == 4) sh[r].bg = data;
            end
        end
        prev0 = (x == 0 && y == 0);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (expq.size() == 2) check(tag, lcd_data, expq.pop_front());
    endtask

    task automatic pix(input int x, input int y, input string tag);
        cycle(x, y, 0, 0, 24'h0, tag);
    endtask

    task automatic wr(input int addr, input logic [23:0] data);
        cycle(int'($urandom_range(1, 2047)), int'($urandom_range(1, 2047)), 1, addr, data, "during_wr");
    endtask

    task automatic do_reset(input int x, input int y);
        xpos = 11'(x); ypos = 11'(y);
        rst = 1'b1;
        #1;
        check("rst_async", lcd_data, 24'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold", lcd_data, 24'h0);
        rst = 1'b0;
    endtask

    task automatic region_pix(input int r, input string tag);
        int x, y;
        x = ac[r].x0 + int'($urandom_range(0, W + 9)) - 5;
        y = ac[r].y0 + int'($urandom_range(0, H + 9)) - 5;
        x = x < 0 ? 0 : (x > 2047 ? 2047 : x);
        y = y < 0 ? 0 : (y > 2047 ? 2047 : y);
        if (x == 0 && y == 0) x = 1;
        pix(x, y, tag);
    endtask

    initial begin
        logic [63:0] v;
        int f, a;
        for (int i = 0; i < W; i++) begin
            v = {$urandom, $urandom};
            dut.g_region[0].u_rom.mem[i] = v;
            rom_m[0][i] = v;
            v = {$urandom, $urandom};
            dut.g_region[1].u_rom.mem[i] = v;
            rom_m[1][i] = v;
        end
        v = 64'h8000_0000_0000_0001;
        dut.g_region[0].u_rom.mem[0] = v;
        rom_m[0][0] = v;

        #2;
        do_reset(5, 5);
        for (int i = 0; i < 20; i++)
            pix(int'($urandom_range(1, 2047)), int'($urandom_range(0, 2047)), "idle_default");

        wr(0, 24'h1);
        wr(1, 24'd64);
        wr(2, 24'd128);
        pix(64, 128, "shadow_not_active");
        pix(0, 0, "frame_start");
        pix(0, 0, "frame_hold");
        pix(64, 128, "r0_top_fg");
        pix(64, 129, "r0_bg");
        pix(64, 191, "r0_bottom_fg");
        pix(63, 128, "r0_left_edge");
        pix(64, 192, "r0_below");
        pix(575, 130, "r0_right_col");
        pix(576, 130, "r0_right_edge");
        for (int i = 0; i < 10; i++) region_pix(0, "r0_rand");

        wr(1, 24'd100);
        pix(64, 128, "old_x0_kept");
        pix(100, 128, "old_x0_col36");
        cycle(0, 0, 1, 3, 24'hFF0000, "fs_with_write");
        pix(100, 128, "new_x0_top");
        pix(99, 128, "new_x0_left");
        pix(611, 130, "new_x0_last");
        pix(612, 130, "new_x0_past");
        pix(0, 0, "frame_start2");
        for (int i = 0; i < 8; i++) region_pix(0, "r0_new_fg");

        wr(1, 24'd64);
        wr(0, 24'h5);
        wr(8, 24'h1);
        wr(9, 24'd64);
        wr(10, 24'd128);
        wr(11, 24'h00FF00);
        wr(12, 24'h112233);
        pix(0, 0, "frame_overlap");
        for (int i = 0; i < 40; i++) region_pix(0, "overlap_transp");
        wr(0, 24'h1);
        pix(0, 0, "frame_opaque");
        for (int i = 0; i < 20; i++) region_pix(0, "overlap_opaque");

        wr(0, 24'h3);
        for (int fr = 0; fr < 6; fr++) begin
            pix(0, 0, "blink_fs");
            for (int i = 0; i < 6; i++) region_pix(0, "blink");
        end

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = int'($urandom_range(0, 15));
                f = a & 7;
                if (f == 1 || f == 2)
                    cycle(int'($urandom_range(1, 2047)), 7, 1, a,
                          $urandom_range(0, 3) == 0 ? 24'($urandom_range(1900, 2047)) : 24'($urandom_range(0, 300)),
                          "rand_wr");
                else
                    cycle(int'($urandom_range(1, 2047)), 7, 1, a, 24'($urandom), "rand_wr");
            end else if ($urandom_range(0, 19) == 0)
                pix(0, 0, "rand_fs");
            else if ($urandom_range(0, 1) == 0)
                region_pix(int'($urandom_range(0, NR - 1)), "rand_region");
            else
                pix(int'($urandom_range(1, 2047)), int'($urandom_range(0, 2047)), "rand_any");
        end

        wr(0, 24'h1);
        wr(8, 24'h1);
        pix(0, 0, "pre_rst_fs");
        pix(300, 150, "pre_rst");
        do_reset(300, 150);
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 0) pix(0, 0, "post_rst_fs");
            else region_pix(int'($urandom_range(0, NR - 1)), "post_rst_default");
        end
        pix(64, 128, "post_rst_r0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_text_overlay.md
# lcd_text_overlay

Parametrised multi-region text/glyph overlay renderer for the LCD/VGA pixel path. For each requested pixel coordinate it returns a 24-bit RGB colour built from up to NUM_REGION independently placed glyph-bitmap regions composited over a default colour. Region position, colours, enable, blink and transparency are runtime-configurable through a simple write port, with tear-free frame-boundary update. It sits between the LCD timing driver (which supplies coordinates 2 cycles ahead) and the LCD data output.

## Interface
- NUM_REGION, 2, number of text regions (1..8); region 0 has highest priority
- REGION_W, 512, region width in pixel columns = glyph ROM depth
- GLYPH_H, 64, region height in rows = glyph ROM word width
- DEFAULT_COLOR, 24'hFFFF00, colour where no region draws
- BLINK_FRAMES, 30, frames per blink half-period (≥1)
- INIT_PREFIX, "vip_rom", ROM init file i is INIT_PREFIX + index + ".mif"
- clk  input  1  pixel clock
- rst  input  1  reset; one clock, asynchronous, active-high
- lcd_xpos  input  11  horizontal coordinate requested by driver
- lcd_ypos  input  11  vertical coordinate requested by driver
- cfg_we  input  1  config write strobe, one write per cycle
- cfg_addr  input  3+clog2(NUM_REGION)  {region, field}
- cfg_wdata  input  24  write data, LSB-aligned
- lcd_data  output  24  registered pixel colour

## Operation
- Per-region fields: 0 ctrl (bit0 enable, bit1 blink, bit2 transparent), 1 x0[10:0], 2 y0[10:0], 3 fg[23:0], 4 bg[23:0]; fields 5-7 and regions ≥ NUM_REGION ignored.
- Writes land in shadow registers; active copies load from shadow on the frame-start cycle (lcd_xpos==0 && lcd_ypos==0, first cycle of that condition only). A write in the same cycle as frame start is visible in the shadow but loads next frame.
- Reset values (shadow and active): ctrl=0, x0=0, y0=0, fg=24'h0000FF, bg=DEFAULT_COLOR.
- Hit i: enable && x0 ≤ x < x0+REGION_W && y0 ≤ y < y0+GLYPH_H, compared in 12 bits (no wrap; region clips at 2047) && !(blink && blink_phase).
- Column address = x − x0 (clog2(REGION_W) bits); row bit = q[GLYPH_H−1−(y−y0)] (MSB = top row).
- Pixel of region i: bit=1 → fg; bit=0 → bg, or "no draw" if transparent.
- Composite: lowest-index region that draws wins; none → DEFAULT_COLOR.
- Blink: frame counter counts frame starts 0..BLINK_FRAMES−1 then wraps and toggles blink_phase; reset counter=0, phase=0 (visible).

## Timing
- Latency fixed 2 cycles: coordinates at cycle N → lcd_data at N+2. Stage 1: hit/row-index registered, ROM address presented (synchronous ROM, 1-cycle read). Stage 2: bit select, composite, lcd_data registered.
- Active-config load and blink update take effect for the coordinate presented on the frame-start cycle itself.
- rst asserted: lcd_data=0, pipeline hit flags cleared, all registers to reset values, immediately (asynchronous), including mid-frame; after release, first valid lcd_data 2 cycles after first coordinate.
- Coordinates are not gated by any valid; every cycle is a pixel.

## Structure
- Shared package/include (alongside lcd_para): colour constants (BLUE, YELLOW), config field codes, CTRL bit positions.
- Sub-module lcd_glyph_rom (DEPTH=REGION_W, WIDTH=GLYPH_H, INIT_FILE), instantiated per region via generate.
- Top holds config bank, frame-start detect, blink counter, 2-stage pipeline, priority mux.

## Test plan
- Reset: rst high → lcd_data=0 immediately; release, no writes, any coordinate → 24'hFFFF00 two cycles later.
- Region 0 enable, x0=64, y0=128, ROM0 column 0 = 64'h8000_0000_0000_0001, then frame start: (64,128)→24'h0000FF, (64,129)→bg 24'hFFFF00, (64,191)→24'h0000FF, (63,128) and (64,192)→DEFAULT_COLOR, all at N+2.
- Shadow update: write x0=100 mid-frame → pixels still rendered at x0=64 until next (0,0); from that cycle region starts at column 100.
- Overlap: regions 0 and 1 both at (64,128); region 0 transparent, bit=0 at a pixel where region 1 bit=1 → region 1 fg; region 0 bit=1 → region 0 fg; region 0 non-transparent → region 0 bg.
- Blink: BLINK_FRAMES=2, region 0 blink set → region visible frames 0-1, hidden frames 2-3 (DEFAULT_COLOR), visible 4-5.
- Reset mid-frame after configuration: rst pulse at (300,150) → lcd_data=0 same cycle; after release all regions disabled, output DEFAULT_COLOR everywhere.
